// File: rtl/serial_compare_sequencer.sv
// Bit-serial MSB-first unsigned comparator with valid/ready handshakes; result after WIDTH edges.
// Define EARLY_TERM_EN to finish at the first differing bit instead of always scanning to bit 0.
module serial_compare_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_less_b,
  output logic             a_eq_b,
  output logic             a_greater_b,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {C_EQ, C_LT, C_GT} cmp_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  cmp_t             cmp_q, cmp_d, res_q, res_d;
  cmp_t             cmp_step;
  logic             last_bit;

  // Once a bit differs the verdict is final; only an "equal" state can change.
  always_comb begin
    cmp_step = cmp_q;
    if (cmp_q == C_EQ) begin
      if (!a_q[WIDTH-1] && b_q[WIDTH-1]) begin
        cmp_step = C_LT;
      end else if (a_q[WIDTH-1] && !b_q[WIDTH-1]) begin
        cmp_step = C_GT;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    last_bit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = CW'(WIDTH - 1);
          cmp_d   = C_EQ;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy  = 1'b1;
        cmp_d = cmp_step;
        a_d   = a_q << 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q - CW'(1);
`ifdef EARLY_TERM_EN
        last_bit = (cnt_q == '0) || (cmp_step != C_EQ);
`else
        last_bit = (cnt_q == '0);
`endif
        if (last_bit) begin
          res_d   = cmp_step;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      cmp_q   <= C_EQ;
      res_q   <= C_EQ;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      res_q   <= res_d;
    end
  end

  // res_q only changes when an operation completes, so outputs stay one-hot between results.
  assign a_less_b    = (res_q == C_LT);
  assign a_eq_b      = (res_q == C_EQ);
  assign a_greater_b = (res_q == C_GT);

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Randomized and directed bench for serial_compare_sequencer against a transaction-level model.
module tb_serial_compare_sequencer;

  localparam int W = 8;

`ifdef EARLY_TERM_EN
  localparam int LAT_80_7F = 1;
  localparam int LAT_00_FF = 1;
  localparam int LAT_C3_C1 = 7;
`else
  localparam int LAT_80_7F = 8;
  localparam int LAT_00_FF = 8;
  localparam int LAT_C3_C1 = 8;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic         a_less_b;
  logic         a_eq_b;
  logic         a_greater_b;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_compare_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_less_b   (a_less_b),
    .a_eq_b     (a_eq_b),
    .a_greater_b(a_greater_b),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Transaction model: phase 0 idle, 1 comparing, 2 result waiting; results as -1/0/+1.
  int  m_phase = 0;
  int  m_left  = 0;
  int  m_pend  = 0;
  int  m_last  = 0;
  bit  started = 1'b0;

  function automatic int model_latency(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) break;
      k++;
    end
`ifdef EARLY_TERM_EN
    return (k == W) ? W : k + 1;
`else
    return W;
`endif
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_phase = 0;
      m_last  = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_pend  = (in_a < in_b) ? -1 : ((in_a > in_b) ? 1 : 0);
          m_left  = model_latency(in_a, in_b);
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2;
            m_last  = m_pend;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [5:0] got, exp;
    if (started) begin
      got = {in_ready, busy, out_valid, a_less_b, a_eq_b, a_greater_b};
      exp = {m_phase == 0, m_phase == 1, m_phase == 2, m_last == -1, m_last == 0, m_last == 1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t {rdy,busy,ov,lt,eq,gt} got=%b expected=%b", $time, got, exp);
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Offers one pair from idle, scrambles operands during the shift, measures edges to out_valid.
  task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat,
                          input logic [2:0] exp_res, input string nm);
    int lat;
    check({nm, " in_ready_before"}, int'(in_ready), 1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid && lat < 40);
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " result_lt_eq_gt"}, int'({a_less_b, a_eq_b, a_greater_b}), int'(exp_res));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", int'({in_ready, busy, out_valid, a_less_b, a_eq_b, a_greater_b}), 6'b100010);

    run_pair(8'h80, 8'h7F, LAT_80_7F, 3'b001, "gt_80_7f"); step();
    run_pair(8'h5A, 8'h5A, 8,         3'b010, "eq_5a_5a"); step();
    run_pair(8'h12, 8'h13, 8,         3'b100, "lt_12_13"); step();
    run_pair(8'h00, 8'hFF, LAT_00_FF, 3'b100, "lt_00_ff"); step();

    out_ready = 1'b0;
    run_pair(8'hC3, 8'hC1, LAT_C3_C1, 3'b001, "hold_c3_c1");
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_result", int'({a_less_b, a_eq_b, a_greater_b}), 3'b001);
    end
    out_ready = 1'b1;
    step();
    check("release_in_ready", int'(in_ready), 1);
    check("release_out_valid", int'(out_valid), 0);

    in_a = 8'h40;
    in_b = 8'h41;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_shift_reset", int'({in_ready, busy, out_valid, a_less_b, a_eq_b, a_greater_b}), 6'b100010);
    run_pair(8'h01, 8'h00, 8, 3'b001, "gt_01_00_after_rst"); step();

    // Back-to-back traffic: in_valid held, operands churn every cycle, stalls and rare resets.
    in_valid = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] a;
      a = W'($urandom);
      in_a = a;
      case ($urandom_range(0, 3))
        0: in_b = a;
        1: in_b = a ^ W'(1 << $urandom_range(0, W - 1));
        default: in_b = W'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_compare_sequencer.md
SERIAL_COMPARE_SEQUENCER -- requirements
Module: serial_compare_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits; legal range WIDTH >= 1.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  sequencer can accept an operand pair.
REQ-006 SHALL have port: in_a  input  WIDTH  operand A, unsigned.
REQ-007 SHALL have port: in_b  input  WIDTH  operand B, unsigned.
REQ-008 SHALL have port: out_valid  output  1  comparison result available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports: a_less_b, a_eq_b, a_greater_b  output  1 each  one-hot comparison result.
REQ-011 SHALL have port: busy  output  1  high while in SHIFT state.

Function
REQ-012 SHALL implement three control states: IDLE, SHIFT, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; accept when in_valid & in_ready at a rising edge; capture in_a/in_b into shift registers and bit counter = WIDTH-1.
REQ-014 SHALL move IDLE->SHIFT on the accepting edge and clear the internal comparator state to "equal".
REQ-015 SHALL present one bit per SHIFT cycle: a[i], b[i] with i counting WIDTH-1 down to 0 (MSB first).
REQ-016 SHALL update the internal comparator state each SHIFT edge: from "equal": a=0,b=1 -> "less"; a=1,b=0 -> "greater"; otherwise hold. "less"/"greater" are final and hold for the rest of the operation.
REQ-017 SHALL, at the SHIFT edge that consumes bit 0, move to DONE and assert out_valid; latency = exactly WIDTH rising edges after the accepting edge (EARLY_TERM_EN exception, REQ-024).
REQ-018 SHALL hold out_valid and the result outputs stable in DONE until out_valid & out_ready at an edge, then move to IDLE; in_ready rises on that edge (no same-cycle bypass; one idle cycle minimum between results and the next accept).
REQ-019 SHALL ignore in_valid, in_a and in_b outside IDLE; operand changes during SHIFT do not affect the result.
REQ-020 SHALL keep a_less_b/a_eq_b/a_greater_b as the last completed result while not in DONE; exactly one of the three is high at all times.
REQ-021 SHALL work for WIDTH=1: single SHIFT cycle, latency 1 edge.
REQ-022 SHALL drive busy = 1 exactly in SHIFT.

Reset
REQ-023 SHALL, when rst is high at a rising edge, regardless of state (including mid-SHIFT or DONE), enter IDLE, abandon any operation, and set out_valid=0, busy=0, a_eq_b=1, a_less_b=0, a_greater_b=0; in_ready=1 in the first cycle after rst is released.

Configuration
REQ-024 SHALL support macro EARLY_TERM_EN: when defined, SHIFT->DONE occurs at the first edge where the comparator state leaves "equal" (latency = k+1 edges, k = number of equal leading MSBs), else after bit 0; when undefined, latency is always WIDTH edges per REQ-017.
REQ-025 SHALL produce identical result values with and without EARLY_TERM_EN; only latency differs.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-026 SHALL cover: a=0x80, b=0x7F -> a_greater_b=1; out_valid 1 edge after accept with EARLY_TERM_EN, 8 edges without.
REQ-027 SHALL cover: a=0x5A, b=0x5A -> a_eq_b=1; out_valid 8 edges after accept in both configurations.
REQ-028 SHALL cover: a=0x12, b=0x13 -> a_less_b=1 after 8 edges in both configurations; a=0x00, b=0xFF -> a_less_b=1 (1 edge with EARLY_TERM_EN).
REQ-029 SHALL cover: out_ready held low 5 cycles in DONE -> out_valid and result stable, in_ready=0; out_ready=1 -> in_ready=1 the following cycle.
REQ-030 SHALL cover: rst pulsed 3 edges into SHIFT -> out_valid=0, busy=0, a_eq_b=1, in_ready=1 after release; the next pair a=0x01, b=0x00 -> a_greater_b=1 with the correct latency.
REQ-031 SHALL cover: back-to-back pairs with in_valid held high and operands changed during SHIFT -> each result matches only the accepted pair.
